// File: rtl/debounce_fsm_pkg.sv
// Shared constants for the switch debouncer: state encoding and default timing.
package debounce_fsm_pkg;

    localparam int DEF_STABLE_CYCLES = 1_000_000;
    localparam int DEF_CNT_W         = 20;

    // Bit 1 of the state is the debounced level and bit 0 is the busy flag.
    localparam logic [1:0] ST_ZERO  = 2'b00;
    localparam logic [1:0] ST_WAIT1 = 2'b01;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_WAIT0 = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: 4-state Moore FSM plus stability counter.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module debounce_fsm
    import debounce_fsm_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic db,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             in_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (in_s)
    );
`else
    assign in_s = in;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ZERO: begin
                if (in_s) begin
                    state_d = ST_WAIT1;
                    cnt_d   = '0;
                end
            end
            ST_WAIT1: begin
                if (!in_s)                state_d = ST_ZERO;
                else if (cnt_q == CNT_LAST) state_d = ST_ONE;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_ONE: begin
                if (!in_s) begin
                    state_d = ST_WAIT0;
                    cnt_d   = '0;
                end
            end
            default: begin // ST_WAIT0
                if (in_s)                 state_d = ST_ONE;
                else if (cnt_q == CNT_LAST) state_d = ST_ZERO;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ZERO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db   = state_q[1];
    assign busy = state_q[0];

endmodule
